// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
// Purpose: FSM state encoding, RV32I load/store funct3 codes and the
//          byte-enable patterns used by load_store_unit and lsu_align.
// Ports:   none (package).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte enables for lane 0; shifted by addr[1:0] for sub-word accesses
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational alignment, lane steering and extension
// Purpose: flags misaligned/illegal accesses, builds byte enables and
//          replicated store data, and extracts/extends load data.
// Ports:
//   is_store   in   1 = store, 0 = load
//   funct3     in   RV32I funct3
//   addr       in   low two address bits
//   wdata      in   raw store data (rs2)
//   rdata      in   raw memory word
//   fault      out  misaligned or illegal funct3
//   be         out  byte enables
//   wdata_rep  out  lane-replicated store data
//   rdata_ext  out  extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  // Addressed lane moved down to bit 0; sub-word loads read from here.
  logic [31:0] lane;
  assign lane = rdata >> {addr, 3'b000};

  always_comb begin
    fault     = 1'b0;
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be        = BE_BYTE << addr;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be        = BE_HALF << addr;
          wdata_rep = {2{wdata[15:0]}};
          fault     = addr[0];
        end
        F3_SW: begin
          be    = BE_WORD;
          fault = |addr;
        end
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB: begin
          be        = BE_BYTE << addr;
          rdata_ext = {{24{lane[7]}}, lane[7:0]};
        end
        F3_LH: begin
          be        = BE_HALF << addr;
          rdata_ext = {{16{lane[15]}}, lane[15:0]};
          fault     = addr[0];
        end
        F3_LW: begin
          be    = BE_WORD;
          fault = |addr;
        end
        F3_LBU: begin
          be        = BE_BYTE << addr;
          rdata_ext = {24'h0, lane[7:0]};
        end
        F3_LHU: begin
          be        = BE_HALF << addr;
          rdata_ext = {16'h0, lane[15:0]};
          fault     = addr[0];
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-access stage with handshaked data memory
// Purpose: accepts one load/store at a time, runs it against the data memory
//          through an IDLE/REQ/WAIT/RESP FSM and returns extended load data.
// Config:  LSU_TIMEOUT_EN - when defined, a watchdog ends a REQ/WAIT that
//          lasts TIMEOUT_CYCLES cycles with resp_error.
// Ports:
//   clk, reset                          clock, async active-high reset
//   req_valid/req_ready                 CPU request handshake
//   req_is_store/funct3/addr/wdata      request fields
//   resp_valid/resp_rdata/resp_error    one-cycle completion
//   stall                               CPU stall
//   mem_req/we/addr/wdata/be            memory request (held until mem_gnt)
//   mem_gnt/mem_rvalid/mem_rdata        memory grant and completion
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        lat_store;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept, capture, timeout_hit, timeout_fire;
  logic        in_idle, in_req, in_wait, in_resp;
  logic        a_store;
  logic [2:0]  a_f3;
  logic [1:0]  a_addr;
  logic [31:0] a_wdata;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;

  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign in_wait = (state_q == ST_WAIT);
  assign in_resp = (state_q == ST_RESP);

  assign accept  = in_idle && req_valid;
  assign capture = (in_req && mem_gnt && mem_rvalid) || (in_wait && mem_rvalid);

  // In IDLE the live request is checked so a fault can skip memory entirely;
  // afterwards the latched copy drives the memory side and load extraction.
  assign a_store = in_idle ? req_is_store    : lat_store;
  assign a_f3    = in_idle ? req_funct3      : lat_f3;
  assign a_addr  = in_idle ? req_addr[1:0]   : lat_addr[1:0];
  assign a_wdata = in_idle ? req_wdata       : lat_wdata;

  lsu_align u_align (
    .is_store  (a_store),
    .funct3    (a_f3),
    .addr      (a_addr),
    .wdata     (a_wdata),
    .rdata     (rdata_q),
    .fault     (fault),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (accept) begin
      cnt_q <= 16'd0;
    end else if (in_req || in_wait) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (in_req || in_wait) && (cnt_q == TIMEOUT_CYCLES[15:0]);
`else
  // No watchdog: the limit only appears in a constant-false term.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  // A completion arriving in the same cycle as the timeout wins.
  assign timeout_fire = timeout_hit && !capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_store <= 1'b0;
      lat_f3    <= 3'b000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_store <= req_is_store;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        err_q     <= fault;
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
      if (timeout_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = fault ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (mem_gnt && mem_rvalid) state_d = ST_RESP;
        else if (mem_gnt)          state_d = ST_WAIT;
      end
      ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (timeout_fire) state_d = ST_RESP;
  end

  assign req_ready  = in_idle;
  assign resp_valid = in_resp;
  assign resp_error = in_resp && err_q;
  assign resp_rdata = (in_resp && !err_q && !lat_store) ? rdata_ext : 32'h0;
  assign stall      = req_valid && !resp_valid;

  // Memory bus is quiet outside REQ so it reads as zero when idle.
  assign mem_req   = in_req;
  assign mem_we    = in_req && lat_store;
  assign mem_addr  = in_req ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata = in_req ? wdata_rep : 32'h0;
  assign mem_be    = in_req ? be : 4'b0000;

endmodule
